psum_drain: RTL
===============

PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning the array dimension; it SHALL match the SIZE of the compute array feeding this block.
REQ-002 SHALL have parameter ACC_WID, default 32, meaning the width of each psum lane and each accumulator.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port psums_in, input, ACC_WID*SIZE*SIZE bits: lane [i*SIZE+j] holds the psum for pixel i, weight j, at bits i*SIZE*ACC_WID + j*ACC_WID upward.
REQ-006 SHALL have port psum_valid, input, 1 bit: psums_in carries a valid K-step.
REQ-007 SHALL have port psum_last, input, 1 bit: marks the final K-step of the current tile; it is qualified by psum_valid.
REQ-008 SHALL have port psum_ready, output, 1 bit: the block accepts a psum beat this cycle.
REQ-009 SHALL have port out_data, output, ACC_WID*SIZE bits: one accumulated row; lane j holds acc[row][j].
REQ-010 SHALL have port out_row, output, clog2(SIZE) bits: the row index of out_data.
REQ-011 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_last (output, 1 bit); out_last is high on the final row of the tile.
REQ-012 SHALL have port tile_cnt, output, 16 bits: the number of tiles fully drained, wrapping at 2^16.

Function
REQ-013 SHALL hold SIZE*SIZE accumulators of ACC_WID bits and a state machine with two states, ACCUM and DRAIN.
REQ-014 In ACCUM, psum_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 In DRAIN, psum_ready SHALL be 0 and out_valid SHALL be 1.
REQ-016 An accept occurs when psum_valid and psum_ready are both 1.
REQ-017 On an accept, if the first flag is 1, every acc lane SHALL load psums_in; otherwise every acc lane SHALL add psums_in, modulo 2^ACC_WID with no saturation and no overflow flag.
REQ-018 On an accept, the first flag SHALL clear; it SHALL be set by reset and on drain completion.
REQ-019 An accept with psum_last=1 SHALL move the state ACCUM->DRAIN on the next edge, with row=0.
REQ-020 After REQ-019, out_valid SHALL be high the cycle after the last beat; latency from last beat to row 0 is 1 cycle.
REQ-021 psum_last with psum_valid=0 SHALL be ignored.
REQ-022 In DRAIN, out_data SHALL equal acc[row] and out_row SHALL equal row, both combinational from the registered row.
REQ-023 out_last SHALL equal (row==SIZE-1) while in DRAIN, and 0 otherwise.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_row and out_last SHALL hold stable.
REQ-025 On an out handshake with row<SIZE-1, row SHALL increment.
REQ-026 On an out handshake with row==SIZE-1, the state SHALL return to ACCUM, the first flag SHALL be set, tile_cnt SHALL increment, and row SHALL return to 0.
REQ-027 A new psum beat SHALL be acceptable on the cycle after the final drain handshake; a drain of SIZE rows with out_ready held high takes exactly SIZE cycles.
REQ-028 A single beat with psum_last=1 while first=1 SHALL be a valid 1-step tile: load, then drain.
REQ-029 The block SHALL never drop or duplicate a psum beat or a row.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL set state=ACCUM, row=0, first=1, tile_cnt=0 and all accumulators=0.
REQ-031 Out of reset, outputs SHALL be psum_ready=1, out_valid=0, out_last=0, out_row=0 and out_data=0.
REQ-032 rst SHALL override every other input, including mid-accumulate and mid-drain; a partial tile is discarded and no row is emitted.

Verification (SIZE=2, ACC_WID=32)
REQ-033 Basic tile: beats all lanes=1, 2, then 3 with last -> row0 = {6,6} and row1 = {6,6}, out_last on row1, tile_cnt=1.
REQ-034 Wrap-around: lane0 gets 0xFFFFFFFF then 0x00000002 with last -> acc[0][0]=0x00000001.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DRAIN -> out_data/out_row stable, psum_ready=0 throughout, then both rows delivered in order.
REQ-036 Back-to-back tiles: tile A = a single beat of 5 with last, drained; next cycle, tile B = a single beat of 7 with last -> rows show 7, not 12, proving first-flag reload.
REQ-037 Reset mid-drain: rst asserted after row0 handshake -> next cycle out_valid=0, psum_ready=1, tile_cnt=0; a new tile of 4 drains as 4.
REQ-038 Lane mapping: lane i*2+j = 10*i+j with last -> row0 = {0,1} and row1 = {10,11}.

Source files
------------

// File: rtl/psum_drain.sv
`default_nettype none
// ============================================================================
// Module   : psum_drain
// Summary  : Accumulates SIZE x SIZE partial sums over the K-steps of a tile,
//            then drains the result one row per handshake.
// Revision : 1.0
// ============================================================================
module psum_drain #(
    parameter int  SIZE    = 8,
    parameter int  ACC_WID = 32,
    localparam int ROW_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                            clock,
    input  logic                            rst,
    input  logic [ACC_WID*SIZE*SIZE-1:0]    psums_in,
    input  logic                            psum_valid,
    input  logic                            psum_last,
    output logic                            psum_ready,
    output logic [ACC_WID*SIZE-1:0]         out_data,
    output logic [ROW_W-1:0]                out_row,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic [15:0]                     tile_cnt
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(SIZE - 1);

    state_t             r_state;
    logic [ROW_W-1:0]   r_row;
    logic               r_first;
    logic [15:0]        r_tile_cnt;

    logic               w_accept;
    logic               w_out_hs;
    logic               w_row_end;
    logic [ACC_WID-1:0] w_acc [SIZE][SIZE];

    assign w_accept  = psum_valid && (r_state == ACCUM);
    assign w_out_hs  = out_ready  && (r_state == DRAIN);
    assign w_row_end = (r_row == c_last_row);

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state    <= ACCUM;
            r_row      <= '0;
            r_first    <= 1'b1;
            r_tile_cnt <= '0;
        end else if (r_state == ACCUM) begin
            if (w_accept) begin
                r_first <= 1'b0;
                if (psum_last) begin
                    r_state <= DRAIN;
                    r_row   <= '0;
                end
            end
        end else begin
            if (w_out_hs) begin
                if (w_row_end) begin
                    // Tile complete: the next accepted beat reloads instead of adding.
                    r_state    <= ACCUM;
                    r_first    <= 1'b1;
                    r_tile_cnt <= r_tile_cnt + 16'd1;
                    r_row      <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            localparam int c_lane = i * SIZE + j;
            logic [ACC_WID-1:0] r_acc;

            always_ff @(posedge clock) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (w_accept) begin
                    r_acc <= r_first ? psums_in[c_lane*ACC_WID +: ACC_WID]
                                     : r_acc + psums_in[c_lane*ACC_WID +: ACC_WID];
                end
            end

            assign w_acc[i][j] = r_acc;
        end
    end

    for (genvar j = 0; j < SIZE; j++) begin : g_out
        assign out_data[j*ACC_WID +: ACC_WID] = (r_state == DRAIN) ? w_acc[r_row][j] : '0;
    end

    assign psum_ready = (r_state == ACCUM);
    assign out_valid  = (r_state == DRAIN);
    assign out_row    = r_row;
    assign out_last   = (r_state == DRAIN) && w_row_end;
    assign tile_cnt   = r_tile_cnt;

endmodule
`default_nettype wire
